// File: rtl/r_peak_pkg.sv
// Shared types and constants for the R-peak sequencing controller.
// Slopes are biased so that a flat signal reads SLOPE_BIAS.
package r_peak_pkg;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        CAND    = 2'd1,
        REFRACT = 2'd2
    } state_e;

    localparam int SLOPE_BIAS = 256;
    localparam int VTH_P_DEF  = 265;
    localparam int VTH_N_DEF  = 250;

    localparam logic CFG_SEL_P = 1'b0;
    localparam logic CFG_SEL_N = 1'b1;

endpackage

// File: rtl/rr_timer.sv
// Saturating R-R sample counter with clear-and-capture and timeout flag.
// cap_o is the interval that a clear on this sample would report.
module rr_timer #(
    parameter int RR_W        = 12,
    parameter int TIMEOUT_SMP = 750
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic            clr_i,
    output logic [RR_W-1:0] cap_o,
    output logic            hit_o
);

    localparam logic [RR_W-1:0] MAX = '1;

    logic [RR_W-1:0] cnt_q;
    logic [RR_W-1:0] inc;
    logic            sat;

    assign sat   = (cnt_q == MAX);
    assign inc   = sat ? cnt_q : cnt_q + 1'b1;
    assign cap_o = inc;
    // Fires only on the sample that lands exactly on the timeout.
    assign hit_o = en_i && !clr_i && !sat
                   && (inc == RR_W'(TIMEOUT_SMP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= clr_i ? '0 : inc;
        end
    end

endmodule

// File: rtl/r_peak_ctrl.sv
// R-peak sequencer: slope thresholds, QRS run qualification,
// refractory window, R-R interval capture and asystole alarm.
module r_peak_ctrl
    import r_peak_pkg::*;
#(
    parameter int DW          = 9,
    parameter int VTH_P_RST   = VTH_P_DEF,
    parameter int VTH_N_RST   = VTH_N_DEF,
    parameter int MIN_QRS     = 2,
    parameter int REFRACT_SMP = 50,
    parameter int TIMEOUT_SMP = 750,
    parameter int RR_W        = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    input  logic [DW-1:0]   s_diff,
    input  logic            cfg_we,
    input  logic            cfg_sel,
    input  logic [DW-1:0]   cfg_data,
    output logic            cfg_err,
    output logic            r_peak,
    output logic            rr_valid,
    output logic [RR_W-1:0] rr_interval,
    output logic            asystole,
    output logic [1:0]      state
);

    localparam int RNW = 4;
    localparam int RFW = $clog2(REFRACT_SMP + 1);

    state_e          state_q;
    logic [RNW-1:0]  run_q;
    logic [RNW-1:0]  run_nx;
    logic [RFW-1:0]  refr_q;
    logic [DW-1:0]   vth_p_q;
    logic [DW-1:0]   vth_n_q;
    logic            first_q;
    logic            r_peak_q;
    logic            rr_valid_q;
    logic            cfg_err_q;
    logic            asys_q;
    logic [RR_W-1:0] rr_int_q;
    logic [RR_W-1:0] rr_cap;
    logic            rr_hit;
    logic            oob;
    logic            confirm;
    logic            cfg_rej;

    assign oob    = (s_diff >= vth_p_q) || (s_diff <= vth_n_q);
    assign run_nx = run_q + 1'b1;

    assign confirm = s_valid && oob
        && ((state_q == ARMED && MIN_QRS == 1)
            || (state_q == CAND && run_nx == RNW'(MIN_QRS)));

    // Keep vth_n strictly below vth_p whichever register is written.
    assign cfg_rej = (cfg_sel == CFG_SEL_P) ? (vth_n_q >= cfg_data)
                                            : (cfg_data >= vth_p_q);

    rr_timer #(
        .RR_W        (RR_W),
        .TIMEOUT_SMP (TIMEOUT_SMP)
    ) u_rr_timer (
        .clk   (clk),
        .rst_n (rst),
        .en_i  (s_valid),
        .clr_i (confirm),
        .cap_o (rr_cap),
        .hit_o (rr_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARMED;
            run_q      <= '0;
            refr_q     <= '0;
            vth_p_q    <= DW'(VTH_P_RST);
            vth_n_q    <= DW'(VTH_N_RST);
            first_q    <= 1'b1;
            r_peak_q   <= 1'b0;
            rr_valid_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            asys_q     <= 1'b0;
            rr_int_q   <= '0;
        end else begin
            r_peak_q   <= 1'b0;
            rr_valid_q <= 1'b0;
            cfg_err_q  <= cfg_we && cfg_rej;
            if (cfg_we && !cfg_rej) begin
                if (cfg_sel == CFG_SEL_P) vth_p_q <= cfg_data;
                else                      vth_n_q <= cfg_data;
            end
            if (rr_hit) asys_q <= 1'b1;
            if (confirm) begin
                r_peak_q   <= 1'b1;
                rr_valid_q <= !first_q;
                first_q    <= 1'b0;
                rr_int_q   <= rr_cap;
                asys_q     <= 1'b0;
                state_q    <= REFRACT;
                refr_q     <= RFW'(REFRACT_SMP);
                run_q      <= '0;
            end else if (s_valid) begin
                unique case (state_q)
                    ARMED: begin
                        if (oob) begin
                            state_q <= CAND;
                            run_q   <= RNW'(1);
                        end
                    end
                    CAND: begin
                        if (oob) begin
                            run_q <= run_nx;
                        end else begin
                            state_q <= ARMED;
                            run_q   <= '0;
                        end
                    end
                    REFRACT: begin
                        refr_q <= refr_q - 1'b1;
                        if (refr_q == RFW'(1)) state_q <= ARMED;
                    end
                    default: state_q <= ARMED;
                endcase
            end
        end
    end

    assign cfg_err     = cfg_err_q;
    assign r_peak      = r_peak_q;
    assign rr_valid    = rr_valid_q;
    assign rr_interval = rr_int_q;
    assign asystole    = asys_q;
    assign state       = state_q;

endmodule

// File: tb/tb_r_peak_ctrl.sv
// Self-checking bench for r_peak_ctrl: directed scenarios plus
// randomized traffic against an event-level reference model.
module tb_r_peak_ctrl;
    import r_peak_pkg::*;

    localparam int MINQ = 2;
    localparam int REFR = 50;
    localparam int TOUT = 750;
    localparam int RRMAX = 4095;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic [8:0]  s_diff = 9'd256;
    logic        cfg_we = 1'b0;
    logic        cfg_sel = 1'b0;
    logic [8:0]  cfg_data = 9'd0;
    logic        cfg_err;
    logic        r_peak;
    logic        rr_valid;
    logic [11:0] rr_interval;
    logic        asystole;
    logic [1:0]  state;

    int n_total = 0;
    int n_pass  = 0;

    r_peak_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_diff      (s_diff),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_data    (cfg_data),
        .cfg_err     (cfg_err),
        .r_peak      (r_peak),
        .rr_valid    (rr_valid),
        .rr_interval (rr_interval),
        .asystole    (asystole),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Reference model: sample indices, run lengths, samples-since-peak.
    int          m_n, m_pk, m_run, m_since, m_vp, m_vn;
    bit          m_first;
    logic        e_peak, e_rrv, e_asys, e_err;
    logic [11:0] e_rri;
    logic [1:0]  e_state;

    function automatic void model_reset();
        m_n = 0; m_pk = -1000; m_run = 0; m_since = 0;
        m_vp = VTH_P_DEF; m_vn = VTH_N_DEF; m_first = 1'b1;
        e_peak = 0; e_rrv = 0; e_asys = 0; e_err = 0;
        e_rri = '0; e_state = 2'd0;
    endfunction

    function automatic void model_step(input bit v, input int d,
                                       input bit we, input bit sel,
                                       input int data);
        bit o;
        e_peak = 0;
        e_rrv  = 0;
        e_err  = we && (sel ? (data >= m_vp) : (m_vn >= data));
        if (v) begin
            o = (d >= m_vp) || (d <= m_vn);
            m_since++;
            if (m_n > m_pk + REFR) begin
                m_run = o ? m_run + 1 : 0;
                if (m_run == MINQ) begin
                    e_peak  = 1;
                    e_rrv   = !m_first;
                    m_first = 0;
                    e_rri   = 12'((m_since > RRMAX) ? RRMAX : m_since);
                    m_since = 0;
                    m_run   = 0;
                    m_pk    = m_n;
                end
            end
            m_n++;
        end
        e_asys = (m_since >= TOUT);
        if (we && !e_err) begin
            if (sel) m_vn = data;
            else     m_vp = data;
        end
        if (m_n - 1 < m_pk + REFR) e_state = 2'd2;
        else if (m_run > 0)        e_state = 2'd1;
        else                       e_state = 2'd0;
    endfunction

    task automatic step(input bit v, input int d, input bit we = 0,
                        input bit sel = 0, input int data = 0);
        s_valid  = v;
        s_diff   = 9'(d);
        cfg_we   = we;
        cfg_sel  = sel;
        cfg_data = 9'(data);
        @(posedge clk);
        model_step(v, d, we, sel, data);
        #1;
        s_valid = 0;
        cfg_we  = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({r_peak, rr_valid, cfg_err, asystole, rr_interval, state}
            !== 18'd0)
            $display("FAIL reset: got pk=%b rrv=%b err=%b asys=%b rri=%0d st=%0d want all 0",
                     r_peak, rr_valid, cfg_err, asystole, rr_interval, state);
        else n_pass++;
    endtask

    task automatic test_qrs_run();
        do_reset();
        step(1, 270);
        n_total++;
        if (r_peak !== 1'b0 || state !== 2'd1)
            $display("FAIL qrs_first: got pk=%b st=%0d want pk=0 st=1", r_peak, state);
        else n_pass++;
        step(1, 270);
        n_total++;
        if (r_peak !== 1'b1 || state !== 2'd2 || rr_valid !== 1'b0)
            $display("FAIL qrs_confirm: got pk=%b st=%0d rrv=%b want pk=1 st=2 rrv=0",
                     r_peak, state, rr_valid);
        else n_pass++;
        step(1, 270);
        for (int i = 0; i < 5; i++) step(1, SLOPE_BIAS);
        n_total++;
        if (r_peak !== 1'b0 || state !== 2'd2)
            $display("FAIL qrs_after: got pk=%b st=%0d want pk=0 st=2", r_peak, state);
        else n_pass++;
    endtask

    task automatic test_spike();
        int peaks = 0;
        do_reset();
        step(1, SLOPE_BIAS);
        step(1, 270);
        peaks += int'(r_peak);
        step(1, SLOPE_BIAS);
        peaks += int'(r_peak);
        step(1, SLOPE_BIAS);
        n_total++;
        if (peaks != 0 || state !== 2'd0)
            $display("FAIL spike: got peaks=%0d st=%0d want peaks=0 st=0", peaks, state);
        else n_pass++;
    endtask

    task automatic test_rr_interval();
        do_reset();
        for (int i = 0; i <= 260; i++) begin
            step(1, (i == 9 || i == 10 || i == 259 || i == 260) ? 270 : SLOPE_BIAS);
            if (i == 10) begin
                n_total++;
                if (r_peak !== 1'b1 || rr_valid !== 1'b0)
                    $display("FAIL rr_first: got pk=%b rrv=%b want pk=1 rrv=0",
                             r_peak, rr_valid);
                else n_pass++;
            end
        end
        n_total++;
        if (r_peak !== 1'b1 || rr_valid !== 1'b1 || rr_interval !== 12'd250)
            $display("FAIL rr_second: got pk=%b rrv=%b rri=%0d want pk=1 rrv=1 rri=250",
                     r_peak, rr_valid, rr_interval);
        else n_pass++;
        step(0, 256);
        step(1, 256);
        n_total++;
        if (rr_valid !== 1'b0 || rr_interval !== 12'd250)
            $display("FAIL rr_hold: got rrv=%b rri=%0d want rrv=0 rri=250",
                     rr_valid, rr_interval);
        else n_pass++;
    endtask

    task automatic test_refractory();
        int peaks = 0;
        int last = -1;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            step(1, (i < 2 || (i >= 20 && i < 23) || i == 52 || i == 53)
                    ? 235 : SLOPE_BIAS);
            if (r_peak === 1'b1) begin
                peaks++;
                last = i;
            end
        end
        n_total++;
        if (peaks != 2 || last != 53)
            $display("FAIL refractory: got peaks=%0d last=%0d want peaks=2 last=53",
                     peaks, last);
        else n_pass++;
    endtask

    task automatic test_asystole();
        do_reset();
        for (int i = 0; i < 760; i++) begin
            step(1, SLOPE_BIAS);
            if (i == 748 || i == 749) begin
                n_total++;
                if (asystole !== (i == 749))
                    $display("FAIL asys_rise_%0d: got %b want %b", i, asystole, i == 749);
                else n_pass++;
            end
        end
        step(1, 275);
        n_total++;
        if (asystole !== 1'b1)
            $display("FAIL asys_hold: got %b want 1", asystole);
        else n_pass++;
        step(1, 275);
        n_total++;
        if (r_peak !== 1'b1 || asystole !== 1'b0)
            $display("FAIL asys_clear: got pk=%b asys=%b want pk=1 asys=0", r_peak, asystole);
        else n_pass++;
    endtask

    task automatic test_cfg();
        do_reset();
        step(0, 256, 1, CFG_SEL_N, 270);
        n_total++;
        if (cfg_err !== 1'b1)
            $display("FAIL cfg_rej_n: got err=%b want 1", cfg_err);
        else n_pass++;
        step(1, 251);
        n_total++;
        if (cfg_err !== 1'b0 || state !== 2'd0)
            $display("FAIL cfg_keep_n: got err=%b st=%0d want err=0 st=0", cfg_err, state);
        else n_pass++;
        step(0, 256, 1, CFG_SEL_P, 250);
        n_total++;
        if (cfg_err !== 1'b1)
            $display("FAIL cfg_rej_p: got err=%b want 1", cfg_err);
        else n_pass++;
        step(1, 280, 1, CFG_SEL_P, 300);
        n_total++;
        if (cfg_err !== 1'b0 || state !== 2'd1)
            $display("FAIL cfg_old_thr: got err=%b st=%0d want err=0 st=1", cfg_err, state);
        else n_pass++;
        step(1, 280);
        n_total++;
        if (state !== 2'd0 || r_peak !== 1'b0)
            $display("FAIL cfg_new_thr: got st=%0d pk=%b want st=0 pk=0", state, r_peak);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1, 270);
        step(1, 270);
        for (int i = 0; i < REFR; i++) step(1, SLOPE_BIAS);
        step(1, 270);
        n_total++;
        if (state !== 2'd1)
            $display("FAIL mid_cand: got st=%0d want 1", state);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if ({r_peak, rr_valid, cfg_err, asystole, rr_interval, state} !== 18'd0)
            $display("FAIL mid_reset: got pk=%b rrv=%b rri=%0d st=%0d want all 0",
                     r_peak, rr_valid, rr_interval, state);
        else n_pass++;
        model_reset();
        #2;
        rst = 1'b1;
        step(1, 270);
        step(1, 270);
        n_total++;
        if (r_peak !== 1'b1 || rr_valid !== 1'b0)
            $display("FAIL mid_first_rearm: got pk=%b rrv=%b want pk=1 rrv=0",
                     r_peak, rr_valid);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (r_peak !== 1'b0 || state !== 2'd0)
            $display("FAIL mid_pulse_kill: got pk=%b st=%0d want pk=0 st=0", r_peak, state);
        else n_pass++;
        model_reset();
        #2;
        rst = 1'b1;
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int  r = int'($urandom_range(0, 9));
            int  d;
            bit  v = ($urandom_range(0, 5) != 0);
            bit  we = ($urandom_range(0, 24) == 0);
            bit  sel = $urandom_range(0, 1) == 1;
            int  data = int'($urandom_range(240, 290));
            if (r < 6)      d = int'($urandom_range(251, 264));
            else if (r < 8) d = int'($urandom_range(265, 290));
            else            d = int'($urandom_range(225, 250));
            step(v, d, we, sel, data);
            n_total++;
            if ({r_peak, rr_valid, rr_interval, asystole, cfg_err, state}
                !== {e_peak, e_rrv, e_rri, e_asys, e_err, e_state}) begin
                if (errs < 10)
                    $display("FAIL random_%0d: got pk=%b rrv=%b rri=%0d asys=%b err=%b st=%0d want pk=%b rrv=%b rri=%0d asys=%b err=%b st=%0d",
                             i, r_peak, rr_valid, rr_interval, asystole, cfg_err, state,
                             e_peak, e_rrv, e_rri, e_asys, e_err, e_state);
                errs++;
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_qrs_run();
        test_spike();
        test_rr_interval();
        test_refractory();
        test_asystole();
        test_cfg();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
